md_unit_resp: RTL

- Multi-cycle multiply/divide responder for the EX stage.
- Accepts a one-cycle `start` plus an `md_op` opcode from the EX-stage controller and holds `busy` for the configured latency.
- Commits results into architectural HI/LO and serves MFHI/MFLO reads combinationally.
- MTHI/MTLO move operands into HI/LO in one cycle.

---
 rtl/md_unit_resp.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit_resp.sv
// md_unit_resp : multi-cycle multiply/divide responder for the EX stage.
//
// A one-cycle start with a MULT/MULTU/DIV/DIVU opcode computes the 64-bit
// result immediately into pending registers. The unit then holds busy for
// MUL_CYCLES or DIV_CYCLES cycles and commits the pending result into the
// architectural HI/LO on the last busy edge. MTHI/MTLO write HI/LO in one
// cycle while idle. MFHI/MFLO reads are served combinationally on md_out.
//
// Optional build macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (md_op 9..12).
// These accumulate into HI/LO at commit time and use MUL_CYCLES latency.
// Without the macro those opcodes are ignored like NOP.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous active-low reset
//   start   in   1   one-cycle request, meaningful with md_op 1..4 (9..12)
//   md_op   in   4   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI,
//                    6 MFLO, 7 MTHI, 8 MTLO (9 MADD, 10 MADDU, 11 MSUB,
//                    12 MSUBU with MDU_MADD_EN)
//   src_a   in   32  forwarded rs operand
//   src_b   in   32  forwarded rt operand
//   busy    out  1   operation in flight (registered)
//   hi      out  32  architectural HI
//   lo      out  32  architectural LO
//   md_out  out  32  hi for MFHI, lo for MFLO, else 0
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight; accepts start, MTHI, MTLO
// RUN   | down-counter running; pending result commits when it hits 1

module md_unit_resp #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_e;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       p_hi_q, p_hi_d;
    logic [31:0]       p_lo_q, p_lo_d;
    logic              commit_q, commit_d;
`ifdef MDU_MADD_EN
    acc_e              acc_q, acc_d;
    logic [63:0]       acc_sum;
    logic [63:0]       acc_diff;
`endif

    // Opcode decode
    logic is_div;
    logic is_signed;
    logic op_valid;
    logic start_ok;

    always_comb begin
        is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
        is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
        op_valid  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
        if ((md_op == OP_MADD) || (md_op == OP_MSUB)) begin
            is_signed = 1'b1;
        end
        if ((md_op == OP_MADD) || (md_op == OP_MADDU) ||
            (md_op == OP_MSUB) || (md_op == OP_MSUBU)) begin
            op_valid = 1'b1;
        end
`endif
        start_ok = start && op_valid && (state_q == IDLE);
    end

    // Multiplier: extend both operands to 64 bits according to signedness;
    // the low 64 bits of the 64x64 product are then exact for either case.
    logic [63:0] opa_ext;
    logic [63:0] opb_ext;
    logic [63:0] prod;

    always_comb begin
        opa_ext = {{32{is_signed & src_a[31]}}, src_a};
        opb_ext = {{32{is_signed & src_b[31]}}, src_b};
        prod    = opa_ext * opb_ext;
    end

    // Divider: divide magnitudes unsigned, then restore signs. This keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, rem 0).
    logic        div_zero;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        div_zero   = (src_b == 32'd0);
        neg_a      = is_signed & src_a[31];
        neg_b      = is_signed & src_b[31];
        mag_a      = neg_a ? (32'd0 - src_a) : src_a;
        mag_b      = neg_b ? (32'd0 - src_b) : src_b;
        // Result is discarded on divide-by-zero; avoid a zero divisor anyway.
        mag_b_safe = div_zero ? 32'd1 : mag_b;
        q_mag      = mag_a / mag_b_safe;
        r_mag      = mag_a % mag_b_safe;
        quo        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem        = neg_a ? (32'd0 - r_mag) : r_mag;
    end

`ifdef MDU_MADD_EN
    always_comb begin
        acc_sum  = {hi_q, lo_q} + {p_hi_q, p_lo_q};
        acc_diff = {hi_q, lo_q} - {p_hi_q, p_lo_q};
    end
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        commit_d = commit_q;
`ifdef MDU_MADD_EN
        acc_d    = acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (is_div) begin
                        p_hi_d   = rem;
                        p_lo_d   = quo;
                        cnt_d    = DIV_LOAD;
                        commit_d = !div_zero;
                    end else begin
                        p_hi_d   = prod[63:32];
                        p_lo_d   = prod[31:0];
                        cnt_d    = MUL_LOAD;
                        commit_d = 1'b1;
                    end
`ifdef MDU_MADD_EN
                    if ((md_op == OP_MADD) || (md_op == OP_MADDU)) begin
                        acc_d = ACC_ADD;
                    end else if ((md_op == OP_MSUB) || (md_op == OP_MSUBU)) begin
                        acc_d = ACC_SUB;
                    end else begin
                        acc_d = ACC_NONE;
                    end
`endif
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (!start && (md_op == OP_MTHI)) begin
                    hi_d = src_a;
                end else if (!start && (md_op == OP_MTLO)) begin
                    lo_d = src_a;
                end
            end

            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    if (commit_q) begin
`ifdef MDU_MADD_EN
                        case (acc_q)
                            ACC_ADD: begin
                                hi_d = acc_sum[63:32];
                                lo_d = acc_sum[31:0];
                            end
                            ACC_SUB: begin
                                hi_d = acc_diff[63:32];
                                lo_d = acc_diff[31:0];
                            end
                            default: begin
                                hi_d = p_hi_q;
                                lo_d = p_lo_q;
                            end
                        endcase
`else
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
`endif
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            p_hi_q   <= 32'd0;
            p_lo_q   <= 32'd0;
            commit_q <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q    <= ACC_NONE;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            commit_q <= commit_d;
`ifdef MDU_MADD_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // MFHI/MFLO read the architectural registers even mid-operation.
    always_comb begin
        case (md_op)
            OP_MFHI: md_out = hi_q;
            OP_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
